// File: rtl/cnt_stat_pkg.sv
// Shared types and defaults for the counter statistics path (accumulator, snapshot stage, register bank).
// Latency: none, declarations only.
// Backpressure: not applicable.
package cnt_stat_pkg;

   // Default accumulator / snapshot width
   localparam int CNT_WIDTH_DEF   = 64;
   // Default snapshot interval in core clock cycles
   localparam int TICK_PERIOD_DEF = 156250000;
   // Default interval timer width, must hold TICK_PERIOD_DEF-1
   localparam int TMR_WIDTH_DEF   = 32;
   // Default width of the saturating lost-snapshot counter
   localparam int LOST_WIDTH_DEF  = 16;
   // Cycles that triggers stay blocked after a clear; this covers the accumulator's
   // two-cycle clear-to-zero latency plus one cycle of margin
   localparam int GUARD_CYCLES    = 3;

   // Snapshot FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      CALC = 2'd2,
      OUT  = 2'd3
   } snap_state_t;

endpackage

// File: rtl/cnt_rate_tmr.sv
// Interval timer plus post-clear guard; produces the qualified snapshot trigger.
// Latency: combinational trigger from the registered timer/guard and the request/clear inputs.
// Backpressure: none; the trigger is a pulse and the consumer decides whether it is dropped.
module cnt_rate_tmr
   import cnt_stat_pkg::*;
#(
   parameter int TICK_PERIOD = TICK_PERIOD_DEF,
   parameter int TMR_WIDTH   = TMR_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr_en,
   input  logic i_snap_req,
   output logic o_trig
);

   localparam logic [TMR_WIDTH-1:0] TMR_LAST   = TMR_WIDTH'(TICK_PERIOD - 1);
   localparam logic [1:0]           GUARD_INIT = 2'(GUARD_CYCLES);

   logic [TMR_WIDTH-1:0] r_timer;
   logic [1:0]           r_guard;
   logic                 w_tick;
   logic                 w_guard_open;

   assign w_tick       = (r_timer == TMR_LAST);
   assign w_guard_open = (r_guard == 2'd0);

   // A tick and a manual request in the same cycle collapse into one trigger;
   // a clear in the same cycle suppresses it entirely.
   assign o_trig = (w_tick | i_snap_req) & ~i_clr_en & w_guard_open;

   // Free-running interval timer, restarted by clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (i_clr_en || w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TMR_WIDTH'(1);
      end
   end

   // Guard counter: loaded by clear, counts down to zero one per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_guard <= 2'd0;
      end else if (i_clr_en) begin
         r_guard <= GUARD_INIT;
      end else if (!w_guard_open) begin
         r_guard <= r_guard - 2'd1;
      end
   end

endmodule

// File: rtl/cnt_rate_snap.sv
// Periodic/manual snapshot of the accumulator total with delta since the previous snapshot.
// Latency: trigger at edge T, snapshot valid after edge T+2 (consumer samples it at T+3); min trigger spacing 4.
// Backpressure: snapshot held stable while snap_ready is low; triggers arriving while busy are dropped and counted.
module cnt_rate_snap
   import cnt_stat_pkg::*;
#(
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int TICK_PERIOD = TICK_PERIOD_DEF,
   parameter int TMR_WIDTH   = TMR_WIDTH_DEF,
   parameter int LOST_WIDTH  = LOST_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CNT_WIDTH-1:0]  cnt_in,
   input  logic                  clr_en,
   input  logic                  snap_req,
   output logic [CNT_WIDTH-1:0]  snap_total,
   output logic [CNT_WIDTH-1:0]  snap_delta,
   output logic                  snap_valid,
   input  logic                  snap_ready,
   output logic [LOST_WIDTH-1:0] snap_lost
);

   snap_state_t           r_state;
   logic [CNT_WIDTH-1:0]  r_cap;
   logic [CNT_WIDTH-1:0]  r_prev;
   logic [CNT_WIDTH-1:0]  r_delta;
   logic [CNT_WIDTH-1:0]  r_snap_total;
   logic [CNT_WIDTH-1:0]  r_snap_delta;
   logic                  r_snap_valid;
   logic [LOST_WIDTH-1:0] r_lost;
   logic                  w_trig;
   logic                  w_busy;
   logic                  w_lost_sat;

   cnt_rate_tmr #(
      .TICK_PERIOD (TICK_PERIOD),
      .TMR_WIDTH   (TMR_WIDTH)
   ) u_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr_en   (clr_en),
      .i_snap_req (snap_req),
      .o_trig     (w_trig)
   );

   assign w_busy     = (r_state != IDLE);
   assign w_lost_sat = (r_lost == {LOST_WIDTH{1'b1}});

   assign snap_total = r_snap_total;
   assign snap_delta = r_snap_delta;
   assign snap_valid = r_snap_valid;
   assign snap_lost  = r_lost;

   // Snapshot FSM and datapath: capture, subtract, present, wait for acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cap        <= '0;
         r_prev       <= '0;
         r_delta      <= '0;
         r_snap_total <= '0;
         r_snap_delta <= '0;
         r_snap_valid <= 1'b0;
      end else if (clr_en) begin
         // Clear abandons any snapshot in flight; the last presented values stay
         // on the bus but are no longer marked valid.
         r_state      <= IDLE;
         r_cap        <= '0;
         r_prev       <= '0;
         r_snap_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_trig) begin
                  r_cap   <= cnt_in;
                  r_state <= CAPT;
               end
            end
            CAPT: begin
               // Unsigned subtraction wraps naturally across the counter rollover
               r_delta <= r_cap - r_prev;
               r_prev  <= r_cap;
               r_state <= CALC;
            end
            CALC: begin
               r_snap_total <= r_cap;
               r_snap_delta <= r_delta;
               r_snap_valid <= 1'b1;
               r_state      <= OUT;
            end
            OUT: begin
               if (snap_ready) begin
                  r_snap_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Saturating count of triggers dropped because a snapshot was already in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lost <= '0;
      end else if (clr_en) begin
         r_lost <= '0;
      end else if (w_trig && w_busy && !w_lost_sat) begin
         r_lost <= r_lost + LOST_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_cnt_rate_snap.sv
// Bench for cnt_rate_snap: directed scenarios plus random traffic against a transaction-level model.
// Latency: model predicts valid two edges after an accepted trigger.
// Backpressure: snap_ready driven both held and randomised.
module tb_cnt_rate_snap;

   localparam int TP = 16;

   logic        clk;
   logic        rst_n;
   logic [63:0] cnt_in;
   logic        clr_en;
   logic        snap_req;
   logic [63:0] snap_total;
   logic [63:0] snap_delta;
   logic        snap_valid;
   logic        snap_ready;
   logic [15:0] snap_lost;

   int total;
   int bad;
   bit ramp;

   // Reference model state (transaction level)
   int          e;
   int          m_timer;
   int          m_guard_until;
   int          m_acc;
   bit          m_active;
   logic [63:0] m_prev;
   logic [63:0] m_pt;
   logic [63:0] m_pd;
   logic [63:0] m_tot;
   logic [63:0] m_del;
   logic        m_valid;
   logic [15:0] m_lost;

   cnt_rate_snap #(
      .CNT_WIDTH   (64),
      .TICK_PERIOD (TP),
      .TMR_WIDTH   (32),
      .LOST_WIDTH  (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_in     (cnt_in),
      .clr_en     (clr_en),
      .snap_req   (snap_req),
      .snap_total (snap_total),
      .snap_delta (snap_delta),
      .snap_valid (snap_valid),
      .snap_ready (snap_ready),
      .snap_lost  (snap_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_timer       = 0;
      m_guard_until = e;
      m_acc         = 0;
      m_active      = 1'b0;
      m_prev        = '0;
      m_pt          = '0;
      m_pd          = '0;
      m_tot         = '0;
      m_del         = '0;
      m_valid       = 1'b0;
      m_lost        = '0;
   endtask

   // Predict the effect of one clock edge from the inputs currently applied
   task automatic model_edge();
      bit tick;
      bit trig;
      bit idle;
      bit in_out;
      e++;
      if (clr_en) begin
         m_timer       = 0;
         m_guard_until = e + 3;
         m_prev        = '0;
         m_active      = 1'b0;
         m_valid       = 1'b0;
         m_lost        = '0;
         return;
      end
      tick    = (m_timer == TP - 1);
      m_timer = (m_timer + 1) % TP;
      trig    = (tick || snap_req) && (e > m_guard_until);
      idle    = !m_active;
      in_out  = m_active && (e >= m_acc + 3);
      if (trig) begin
         if (idle) begin
            m_active = 1'b1;
            m_acc    = e;
            m_pt     = cnt_in;
            m_pd     = cnt_in - m_prev;
            m_prev   = cnt_in;
         end else if (m_lost != 16'hFFFF) begin
            m_lost = m_lost + 16'd1;
         end
      end
      if (in_out && snap_ready) begin
         m_active = 1'b0;
         m_valid  = 1'b0;
      end
      if (m_active && e == m_acc + 2) begin
         m_valid = 1'b1;
         m_tot   = m_pt;
         m_del   = m_pd;
      end
   endtask

   task automatic compare_outputs();
      check("model_valid", {63'd0, snap_valid}, {63'd0, m_valid});
      check("model_lost", {48'd0, snap_lost}, {48'd0, m_lost});
      check("model_total", snap_total, m_tot);
      check("model_delta", snap_delta, m_del);
   endtask

   // One clock: model the edge, let the DUT take it, drop pulse inputs, compare
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      snap_req = 1'b0;
      clr_en   = 1'b0;
      if (ramp) cnt_in = cnt_in + 64'd5;
      compare_outputs();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total      = 0;
      bad        = 0;
      e          = 0;
      ramp       = 1'b0;
      rst_n      = 1'b0;
      cnt_in     = '0;
      clr_en     = 1'b0;
      snap_req   = 1'b0;
      snap_ready = 1'b1;
      model_reset();

      // Reset state
      #1;
      check("rst_valid", {63'd0, snap_valid}, 64'd0);
      check("rst_total", snap_total, 64'd0);
      check("rst_delta", snap_delta, 64'd0);
      check("rst_lost", {48'd0, snap_lost}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // Ramp: +5 per cycle, tick every 16 cycles, consumer always ready
      ramp = 1'b1; cnt_in = '0; clr_en = 1'b1;
      step();
      repeat (18) step();
      check("ramp_valid1", {63'd0, snap_valid}, 64'd1);
      check("ramp_total1", snap_total, 64'd80);
      check("ramp_delta1", snap_delta, 64'd80);
      for (int k = 2; k <= 4; k++) begin
         repeat (16) step();
         check("ramp_total", snap_total, 64'(80 * k));
         check("ramp_delta", snap_delta, 64'd80);
      end

      // Back-pressure: hold snap_ready low across three further ticks
      snap_ready = 1'b0; cnt_in = '0; clr_en = 1'b1;
      step();
      repeat (18) step();
      check("bp_total_first", snap_total, 64'd80);
      repeat (46) step();
      check("bp_lost3", {48'd0, snap_lost}, 64'd3);
      check("bp_valid_held", {63'd0, snap_valid}, 64'd1);
      check("bp_total_held", snap_total, 64'd80);
      check("bp_delta_held", snap_delta, 64'd80);
      snap_ready = 1'b1;
      step();
      repeat (17) step();
      check("bp_total_after", snap_total, 64'd400);
      check("bp_delta_4int", snap_delta, 64'd320);
      check("bp_lost_kept", {48'd0, snap_lost}, 64'd3);

      // Manual request coincident with a tick
      cnt_in = '0; clr_en = 1'b1;
      step();
      repeat (15) step();
      snap_req = 1'b1;
      step();
      repeat (2) step();
      check("mt_valid", {63'd0, snap_valid}, 64'd1);
      check("mt_delta", snap_delta, 64'd80);
      check("mt_lost", {48'd0, snap_lost}, 64'd0);
      step();
      repeat (12) step();
      check("mt_single", {63'd0, snap_valid}, 64'd0);
      check("mt_lost_after", {48'd0, snap_lost}, 64'd0);

      // Make one lost trigger, then clear and check guard and wrap-safe delta
      snap_req = 1'b1; step();
      snap_req = 1'b1; step();
      check("pre_clr_lost", {48'd0, snap_lost}, 64'd1);
      ramp = 1'b0; cnt_in = '0; clr_en = 1'b1;
      step();
      check("clr_valid", {63'd0, snap_valid}, 64'd0);
      check("clr_lost", {48'd0, snap_lost}, 64'd0);
      cnt_in = 64'h123; snap_req = 1'b1;
      step();
      check("guard_lost", {48'd0, snap_lost}, 64'd0);
      repeat (2) step();
      cnt_in = 64'hFFFF_FFFF_FFFF_FFF0; snap_req = 1'b1;
      step();
      repeat (2) step();
      check("clr_snap_valid", {63'd0, snap_valid}, 64'd1);
      check("clr_snap_total", snap_total, 64'hFFFF_FFFF_FFFF_FFF0);
      check("clr_snap_delta", snap_delta, 64'hFFFF_FFFF_FFFF_FFF0);
      repeat (3) step();
      cnt_in = 64'h10; snap_req = 1'b1;
      step();
      repeat (2) step();
      check("wrap_total", snap_total, 64'h10);
      check("wrap_delta", snap_delta, 64'h20);

      // Asynchronous reset while the FSM sits in CALC
      step();
      cnt_in = 64'h55; snap_req = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, snap_valid}, 64'd0);
      check("arst_total", snap_total, 64'd0);
      check("arst_delta", snap_delta, 64'd0);
      check("arst_lost", {48'd0, snap_lost}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat (10) step();
      check("arst_no_snap", {63'd0, snap_valid}, 64'd0);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         cnt_in     = {$urandom, $urandom};
         snap_req   = ($urandom_range(0, 5) == 0);
         snap_ready = $urandom_range(0, 1) == 1;
         clr_en     = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
